// File: rtl/cpu_pkg.sv
// Definitions shared between the instruction-memory loader and the instruction memory.
// Holds the loader state encoding, the frame length width and the instruction word width.
package cpu_pkg;

    localparam int LOADER_LEN_W = 16;
    localparam int INSTR_W      = 32;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA,
        LD_WRITE,
        LD_CSUM,
        LD_DONE,
        LD_ERR
    } loader_state_e;

    // States in which the byte link may hand over a byte.
    function automatic logic accepts_bytes(input loader_state_e s);
        return (s == LD_LEN_HI) || (s == LD_LEN_LO) || (s == LD_DATA) || (s == LD_CSUM);
    endfunction

    function automatic logic is_loading(input loader_state_e s);
        return accepts_bytes(s) || (s == LD_WRITE);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a stream of bytes into big-endian instruction words, first byte in the MSBs.
// word_full flags the shift that completes a word; the finished word is visible the next cycle.
import cpu_pkg::*;

module imem_word_packer (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_full
);

    logic [INSTR_W-1:0] word_q, word_d;
    logic [1:0]         cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            word_d = '0;
            cnt_d  = 2'd0;
        end else if (shift_en) begin
            word_d = {word_q[INSTR_W-9:0], byte_in};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word      = word_q;
    assign word_full = shift_en && !clear && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Receives a framed byte stream (length, data words, XOR checksum) and writes the image
// into the instruction memory write port, stalling the CPU until the image is verified.
import cpu_pkg::*;

module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               cpu_hold,
    output logic [ADDR_W:0]    words_loaded
);

    loader_state_e            state_q, state_d;
    logic [LOADER_LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W:0]          words_q, words_d;
    logic [7:0]               csum_q, csum_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
    logic                     mem_we_q, mem_we_d;
    logic                     byte_ready_q, byte_ready_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     cpu_hold_q, cpu_hold_d;

    logic                     accept;
    logic                     pack_clear;
    logic                     pack_shift;
    logic                     pack_full;
    logic [INSTR_W-1:0]       pack_word;
    logic [LOADER_LEN_W-1:0]  len_full;
    logic [ADDR_W:0]          words_inc;

    imem_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .shift_en  (pack_shift),
        .byte_in   (byte_data),
        .word      (pack_word),
        .word_full (pack_full)
    );

    assign accept    = byte_valid && byte_ready_q;
    assign len_full  = {len_q[LOADER_LEN_W-1:8], byte_data};
    assign words_inc = words_q + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        words_d    = words_q;
        csum_d     = csum_q;
        mem_addr_d = mem_addr_q;
        pack_clear = 1'b0;
        pack_shift = 1'b0;

        case (state_q)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start) begin
                    state_d    = LD_LEN_HI;
                    words_d    = '0;
                    csum_d     = 8'h00;
                    pack_clear = 1'b1;
                end
            end
            LD_LEN_HI: begin
                if (accept) begin
                    len_d   = {byte_data, len_q[7:0]};
                    state_d = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full > LOADER_LEN_W'(MAX_WORDS)) begin
                        state_d = LD_ERR;
                    end else if (len_full == '0) begin
                        state_d = LD_CSUM;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ byte_data;
                    pack_shift = 1'b1;
                    if (pack_full) begin
                        state_d    = LD_WRITE;
                        mem_addr_d = words_q[ADDR_W-1:0];
                    end
                end
            end
            LD_WRITE: begin
                words_d = words_inc;
                state_d = (LOADER_LEN_W'(words_inc) == len_q) ? LD_CSUM : LD_DATA;
            end
            LD_CSUM: begin
                if (accept) begin
                    state_d = (byte_data == csum_q) ? LD_DONE : LD_ERR;
                end
            end
            default: state_d = LD_IDLE;
        endcase

        // Status outputs are registered by decoding the state being entered.
        mem_we_d     = (state_d == LD_WRITE);
        byte_ready_d = accepts_bytes(state_d);
        busy_d       = is_loading(state_d);
        done_d       = (state_d == LD_DONE);
        error_d      = (state_d == LD_ERR);
        cpu_hold_d   = busy_d || error_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LD_IDLE;
            len_q        <= '0;
            words_q      <= '0;
            csum_q       <= 8'h00;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            words_q      <= words_d;
            csum_q       <= csum_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_hold_q   <= cpu_hold_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = pack_word;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = cpu_hold_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives framed byte streams and models the instruction
// memory from the write port to check contents, status flags and handshake behaviour.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;
    logic [8:0]  words_loaded;

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_mem [0:255];
    int          wr_count   = 0;
    int          ready_viol = 0;
    logic [7:0]  last_addr  = 8'h00;

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cpu_hold     (cpu_hold),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Instruction memory model fed by the write port; also watches the handshake in WRITE.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            tb_mem[mem_addr] = mem_wdata;
            wr_count         = wr_count + 1;
            last_addr        = mem_addr;
            if (byte_ready !== 1'b0) ready_viol = ready_viol + 1;
        end
    end

    function automatic logic [31:0] fetch(input logic [15:0] pc);
        return tb_mem[pc[8:1]];
    endfunction

    function automatic logic [31:0] pat_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, b ^ 8'h5A, 8'(i * 7), b ^ 8'hC3};
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_byte timeout: byte_ready=%b required 1 for byte %h", byte_ready, b);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({byte_ready, mem_we, busy, done, error, cpu_hold} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 000000", {byte_ready, mem_we, busy, done, error, cpu_hold});
        end
        checks++;
        if ({mem_addr, mem_wdata, words_loaded} !== 49'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: addr=%h wdata=%h words=%0d required all 0", mem_addr, mem_wdata, words_loaded);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int base;
        base = wr_count;
        // start and a byte together in IDLE: the byte must not be taken.
        start = 1'b1; byte_valid = 1'b1; byte_data = 8'h00;
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_len_hi: busy=%b ready=%b required 1 1", busy, byte_ready);
        end
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 1); send_byte(8'h56, 0); send_byte(8'h78, 0);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'h12345678 || byte_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_write_latency: we=%b addr=%h data=%h ready=%b required 1 00 12345678 0",
                     mem_we, mem_addr, mem_wdata, byte_ready);
        end
        send_word(32'hDEADBEEF, 0);
        send_byte(8'h2A, 2);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0 || words_loaded !== 9'd2) begin
            errors++;
            $display("[TB] FAIL basic_status: done=%b err=%b hold=%b busy=%b words=%0d required 1 0 0 0 2",
                     done, error, cpu_hold, busy, words_loaded);
        end
        checks++;
        if (wr_count - base != 2 || tb_mem[0] !== 32'h12345678 || tb_mem[1] !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL basic_mem: writes=%0d m0=%h m1=%h required 2 12345678 DEADBEEF",
                     wr_count - base, tb_mem[0], tb_mem[1]);
        end
        checks++;
        if (fetch(16'h0002) !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL basic_fetch: got %h required DEADBEEF", fetch(16'h0002));
        end
    endtask

    task automatic test_csum_error();
        int base;
        base = wr_count;
        tb_mem[0] = 32'h0; tb_mem[1] = 32'h0;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_word(32'h12345678, 0); send_word(32'hDEADBEEF, 0);
        send_byte(8'hD5, 0);
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL csum_status: err=%b done=%b hold=%b busy=%b required 1 0 1 0", error, done, cpu_hold, busy);
        end
        checks++;
        if (wr_count - base != 2 || tb_mem[0] !== 32'h12345678 || tb_mem[1] !== 32'hDEADBEEF || words_loaded !== 9'd2) begin
            errors++;
            $display("[TB] FAIL csum_mem: writes=%0d m0=%h m1=%h words=%0d required 2 12345678 DEADBEEF 2",
                     wr_count - base, tb_mem[0], tb_mem[1], words_loaded);
        end
    endtask

    task automatic test_len_overflow();
        int base;
        base = wr_count;
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        checks++;
        if (error !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_status: err=%b ready=%b busy=%b hold=%b done=%b required 1 0 0 1 0",
                     error, byte_ready, busy, cpu_hold, done);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wr_count - base != 0 || error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_nowrite: writes=%0d err=%b required 0 1", wr_count - base, error);
        end
    endtask

    task automatic test_full_image();
        int         base;
        int         bad;
        int         first_bad;
        logic [7:0] cs;
        logic [31:0] w;
        base = wr_count;
        cs = 8'h00;
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h0;
        pulse_start();
        send_byte(8'h01, 1); send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            w = pat_word(i);
            for (int k = 3; k >= 0; k--) begin
                cs = cs ^ w[8*k +: 8];
                send_byte(w[8*k +: 8], ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
            end
        end
        send_byte(cs, 1);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 9'd256 || last_addr !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL full_status: done=%b err=%b words=%0d last_addr=%h required 1 0 256 FF",
                     done, error, words_loaded, last_addr);
        end
        checks++;
        if (wr_count - base != 256 || ready_viol != 0) begin
            errors++;
            $display("[TB] FAIL full_writes: writes=%0d ready_in_write=%0d required 256 0", wr_count - base, ready_viol);
        end
        bad = 0; first_bad = -1;
        for (int i = 0; i < 256; i++) begin
            if (tb_mem[i] !== pat_word(i)) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL full_scoreboard: %0d bad words, first at %0d got %h required %h",
                     bad, first_bad, tb_mem[first_bad], pat_word(first_bad));
        end
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h05, 0);
        send_word(32'h01020304, 0); send_word(32'h05060708, 1); send_word(32'h090A0B0C, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({byte_ready, mem_we, busy, done, error, cpu_hold} !== 6'b0 || {mem_addr, mem_wdata, words_loaded} !== 49'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: flags=%b addr=%h wdata=%h words=%0d required all 0",
                     {byte_ready, mem_we, busy, done, error, cpu_hold}, mem_addr, mem_wdata, words_loaded);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tb_mem[0] !== 32'h01020304 || tb_mem[1] !== 32'h05060708 || tb_mem[2] !== 32'h090A0B0C) begin
            errors++;
            $display("[TB] FAIL midreset_partial: m0=%h m1=%h m2=%h required 01020304 05060708 090A0B0C",
                     tb_mem[0], tb_mem[1], tb_mem[2]);
        end
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'hC9, 0);
        checks++;
        if (done !== 1'b1 || words_loaded !== 9'd1 || tb_mem[0] !== 32'hCAFEF00D || tb_mem[1] !== 32'h05060708) begin
            errors++;
            $display("[TB] FAIL midreset_reload: done=%b words=%0d m0=%h m1=%h required 1 1 CAFEF00D 05060708",
                     done, words_loaded, tb_mem[0], tb_mem[1]);
        end
    endtask

    task automatic test_start_handling();
        int base;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1 || words_loaded !== 9'd0) begin
            errors++;
            $display("[TB] FAIL start_busy_ignored: busy=%b ready=%b words=%0d required 1 1 0", busy, byte_ready, words_loaded);
        end
        send_byte(8'hCC, 0); send_byte(8'hDD, 0);
        send_word(32'h11223344, 0);
        send_byte(8'h44, 0);
        checks++;
        if (done !== 1'b1 || tb_mem[0] !== 32'hAABBCCDD || tb_mem[1] !== 32'h11223344) begin
            errors++;
            $display("[TB] FAIL start_busy_frame: done=%b m0=%h m1=%h required 1 AABBCCDD 11223344", done, tb_mem[0], tb_mem[1]);
        end
        pulse_start();
        checks++;
        if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b1 || words_loaded !== 9'd0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_from_done: done=%b err=%b busy=%b words=%0d hold=%b required 0 0 1 0 1",
                     done, error, busy, words_loaded, cpu_hold);
        end
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_word(32'h0BADC0DE, 0);
        send_byte(8'hB8, 0);
        checks++;
        if (done !== 1'b1 || last_addr !== 8'h00 || tb_mem[0] !== 32'h0BADC0DE || words_loaded !== 9'd1) begin
            errors++;
            $display("[TB] FAIL start_overwrite: done=%b last_addr=%h m0=%h words=%0d required 1 00 0BADC0DE 1",
                     done, last_addr, tb_mem[0], words_loaded);
        end
        base = wr_count;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 9'd0 || wr_count - base != 0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_image: done=%b err=%b words=%0d writes=%0d hold=%b required 1 0 0 0 0",
                     done, error, words_loaded, wr_count - base, cpu_hold);
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_csum_error();
        test_len_overflow();
        test_full_image();
        test_reset_mid_load();
        test_start_handling();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
